// File: rtl/rv32im_decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rv32im_decode_stage: RV32IM instruction decode plus ID/EX register.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module rv32im_decode_stage #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [2:0]      ex_alu_class,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    localparam logic [6:0] c_OP_REG = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_LUI = 7'b0110111;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MULD = 7'b0000001;

    localparam logic [2:0] c_CLASS_R = 3'b000;
    localparam logic [2:0] c_CLASS_I = 3'b001;
    localparam logic [2:0] c_CLASS_U = 3'b011;
    localparam logic [2:0] c_CLASS_J = 3'b110;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic            w_transfer;

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [2:0]      w_class;
    logic            w_legal;

    logic            r_valid;

    assign w_opcode = if_instr[6:0];
    assign w_f3     = if_instr[14:12];
    assign w_f7     = if_instr[31:25];
    assign w_rd     = if_instr[11:7];

    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    assign if_ready   = !r_valid || ex_ready;
    assign w_transfer = if_valid && if_ready && !flush;
    assign ex_valid   = r_valid;

    always_comb begin
        w_op1    = '0;
        w_op2    = '0;
        w_funct3 = w_f3;
        w_funct7 = '0;
        w_class  = c_CLASS_R;
        w_legal  = 1'b0;
        case (w_opcode)
            c_OP_REG: begin
                w_op1    = rs1_data;
                w_op2    = rs2_data;
                w_funct7 = w_f7;
                w_class  = c_CLASS_R;
                w_legal  = (w_f7 == c_F7_BASE)
                        || ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
                        || ((M_EXT != 0) && (w_f7 == c_F7_MULD));
            end
            c_OP_IMM: begin
                w_op1   = rs1_data;
                w_class = c_CLASS_I;
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                    // Shifts carry the shamt in the rs2 field and the variant in funct7.
                    w_op2    = {27'b0, if_instr[24:20]};
                    w_funct7 = w_f7;
                    w_legal  = (w_f7 == c_F7_BASE)
                            || ((w_f7 == c_F7_ALT) && (w_f3 == 3'b101));
                end else begin
                    w_op2   = {{20{if_instr[31]}}, if_instr[31:20]};
                    w_legal = 1'b1;
                end
            end
            c_OP_LUI: begin
                w_op2    = {if_instr[31:12], 12'b0};
                w_funct3 = 3'b000;
                w_class  = c_CLASS_U;
                w_legal  = 1'b1;
            end
            c_OP_JAL: begin
                w_op1    = if_pc;
                w_op2    = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
                w_funct3 = 3'b000;
                w_class  = c_CLASS_J;
                w_legal  = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        // Illegal encodings still flow to EX as a bubble-like bundle so it can trap.
        if (!w_legal) begin
            w_op1    = '0;
            w_op2    = '0;
            w_funct7 = '0;
            w_class  = c_CLASS_R;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_funct3    <= '0;
            ex_funct7    <= '0;
            ex_alu_class <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_pc        <= '0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_transfer) begin
            r_valid      <= 1'b1;
            ex_op1       <= w_op1;
            ex_op2       <= w_op2;
            ex_funct3    <= w_funct3;
            ex_funct7    <= w_funct7;
            ex_alu_class <= w_class;
            ex_rd        <= w_rd;
            ex_reg_write <= w_legal && (w_rd != 5'd0);
            ex_pc        <= if_pc;
            ex_illegal   <= !w_legal;
        end else if (ex_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32im_decode_stage.sv
`default_nettype none
// Directed testbench for rv32im_decode_stage (M extension disabled).
module tb_rv32im_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [2:0]  ex_alu_class;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [31:0] ex_pc;
    logic        ex_illegal;

    int vectors;
    int miscompares;

    rv32im_decode_stage #(.XLEN(32), .M_EXT(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_funct3    (ex_funct3),
        .ex_funct7    (ex_funct7),
        .ex_alu_class (ex_alu_class),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_pc        (ex_pc),
        .ex_illegal   (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n  = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'h0;
        if_pc    = 32'h0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        flush    = 1'b0;
        ex_ready = 1'b1;

        #12;
        chk("rst_valid",   {31'b0, ex_valid}, 32'd0);
        chk("rst_op1",     ex_op1, 32'd0);
        chk("rst_op2",     ex_op2, 32'd0);
        chk("rst_class",   {29'b0, ex_alu_class}, 32'd0);
        chk("rst_illegal", {31'b0, ex_illegal}, 32'd0);
        chk("rst_ready",   {31'b0, if_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // ADD x3,x1,x2
        if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h40;
        rs1_data = 32'd5; rs2_data = 32'd7;
        #1;
        chk("add_rs1a", {27'b0, rs1_addr}, 32'd1);
        chk("add_rs2a", {27'b0, rs2_addr}, 32'd2);
        tick();
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_op1",   ex_op1, 32'd5);
        chk("add_op2",   ex_op2, 32'd7);
        chk("add_f3",    {29'b0, ex_funct3}, 32'd0);
        chk("add_f7",    {25'b0, ex_funct7}, 32'd0);
        chk("add_class", {29'b0, ex_alu_class}, 32'd0);
        chk("add_rd",    {27'b0, ex_rd}, 32'd3);
        chk("add_rw",    {31'b0, ex_reg_write}, 32'd1);
        chk("add_pc",    ex_pc, 32'h40);
        chk("add_ill",   {31'b0, ex_illegal}, 32'd0);

        // ADDI x1,x0,-1
        if_instr = 32'hFFF00093; rs1_data = 32'd0; rs2_data = 32'h55;
        tick();
        chk("addi_op1",   ex_op1, 32'd0);
        chk("addi_op2",   ex_op2, 32'hFFFFFFFF);
        chk("addi_class", {29'b0, ex_alu_class}, 32'd1);
        chk("addi_rd",    {27'b0, ex_rd}, 32'd1);

        // SRAI x2,x2,3
        if_instr = 32'h40315113; rs1_data = 32'h80;
        tick();
        chk("srai_op1", ex_op1, 32'h80);
        chk("srai_op2", ex_op2, 32'd3);
        chk("srai_f7",  {25'b0, ex_funct7}, 32'h20);
        chk("srai_f3",  {29'b0, ex_funct3}, 32'd5);
        chk("srai_ill", {31'b0, ex_illegal}, 32'd0);

        // LUI x5,0x12345
        if_instr = 32'h123452B7; rs1_data = 32'hDEAD;
        tick();
        chk("lui_op1",   ex_op1, 32'd0);
        chk("lui_op2",   ex_op2, 32'h12345000);
        chk("lui_class", {29'b0, ex_alu_class}, 32'd3);
        chk("lui_rd",    {27'b0, ex_rd}, 32'd5);

        // JAL x1,+8 at 0x100
        if_instr = 32'h008000EF; if_pc = 32'h100;
        tick();
        chk("jal_op1",   ex_op1, 32'h100);
        chk("jal_op2",   ex_op2, 32'd8);
        chk("jal_class", {29'b0, ex_alu_class}, 32'd6);
        chk("jal_rd",    {27'b0, ex_rd}, 32'd1);
        chk("jal_f3",    {29'b0, ex_funct3}, 32'd0);

        // MUL with M_EXT=0 is illegal
        if_instr = 32'h022081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        tick();
        chk("mul_ill",   {31'b0, ex_illegal}, 32'd1);
        chk("mul_rw",    {31'b0, ex_reg_write}, 32'd0);
        chk("mul_valid", {31'b0, ex_valid}, 32'd1);
        chk("mul_op1",   ex_op1, 32'd0);

        // All-zero word
        if_instr = 32'h00000000;
        tick();
        chk("zero_ill",   {31'b0, ex_illegal}, 32'd1);
        chk("zero_rw",    {31'b0, ex_reg_write}, 32'd0);
        chk("zero_valid", {31'b0, ex_valid}, 32'd1);

        // ADD x0 suppresses writeback
        if_instr = 32'h00208033;
        tick();
        chk("x0_rw",  {31'b0, ex_reg_write}, 32'd0);
        chk("x0_ill", {31'b0, ex_illegal}, 32'd0);

        // Stall: ADD loaded, then held 3 cycles with ADDI waiting
        if_instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        tick();
        ex_ready = 1'b0;
        if_instr = 32'hFFF00093; rs1_data = 32'd0;
        #1;
        chk("stall_rdy", {31'b0, if_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, ex_valid}, 32'd1);
            chk("stall_op2",   ex_op2, 32'd7);
            chk("stall_rd",    {27'b0, ex_rd}, 32'd3);
        end
        ex_ready = 1'b1;
        #1;
        chk("rel_rdy", {31'b0, if_ready}, 32'd1);
        tick();
        chk("rel_op2",   ex_op2, 32'hFFFFFFFF);
        chk("rel_valid", {31'b0, ex_valid}, 32'd1);
        if_valid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, ex_valid}, 32'd0);

        // Flush kills a same-cycle transfer
        if_valid = 1'b1; if_instr = 32'h002081B3; flush = 1'b1;
        tick();
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        flush = 1'b0;

        // Asynchronous reset mid-stall
        if_instr = 32'h123452B7;
        tick();
        chk("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
        ex_ready = 1'b0; if_valid = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, ex_valid}, 32'd0);
        chk("arst_op2",   ex_op2, 32'd0);
        chk("arst_class", {29'b0, ex_alu_class}, 32'd0);
        chk("arst_rd",    {27'b0, ex_rd}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ex_ready = 1'b1;
        if_valid = 1'b1; if_instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        tick();
        chk("post_valid", {31'b0, ex_valid}, 32'd1);
        chk("post_op1",   ex_op1, 32'd5);
        chk("post_rd",    {27'b0, ex_rd}, 32'd3);
        if_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
